// File: rtl/wb_rr_interconnect.sv
// Wishbone shared-bus interconnect: NM masters, NS slaves, round-robin grant,
// top-bits address decode, bus error on unmapped addresses and a stall watchdog.
module wb_rr_interconnect #(
    parameter int unsigned      NM          = 2,
    parameter int unsigned      NS          = 6,
    parameter int unsigned      AW          = 3,
    parameter logic [NS*AW-1:0] SLAVE_ADDRS = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
    parameter int unsigned      TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*32-1:0] m_adr_i,
    input  logic [NM*32-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [31:0]      m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [31:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*32-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i
);

    localparam int unsigned GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] LAST_RST = GW'(NM - 1);

    logic          gnt_valid_q, gnt_valid_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          err_pend_q, err_pend_d;

    logic          g_cyc, g_stb, g_we;
    logic [31:0]   g_adr, g_dat;
    logic [3:0]    g_sel;
    logic [NS-1:0] sel;
    logic          sel_any;
    logic [31:0]   rdat;
    logic          ack_sel, ack, stb_active;
    logic          found_hi, found_lo;
    logic [GW-1:0] win_hi, win_lo;
    logic          unmapped, wd_fire;

    // Granted master's bus; all zero while nobody holds the grant.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_valid_q && gnt_q == GW'(i)) begin
                g_cyc = m_cyc_i[i];
                g_stb = m_stb_i[i];
                g_we  = m_we_i[i];
                g_adr = m_adr_i[i*32 +: 32];
                g_dat = m_dat_i[i*32 +: 32];
                g_sel = m_sel_i[i*4 +: 4];
            end
        end
    end

    // Lowest matching slave index wins.
    always_comb begin
        sel     = '0;
        sel_any = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (gnt_valid_q && !sel_any && g_adr[31 -: AW] == SLAVE_ADDRS[i*AW +: AW]) begin
                sel[i]  = 1'b1;
                sel_any = 1'b1;
            end
        end
    end

    always_comb begin
        rdat    = '0;
        ack_sel = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (sel[i]) begin
                rdat    = s_dat_i[i*32 +: 32];
                ack_sel = s_ack_i[i];
            end
        end
    end

    assign s_cyc_o    = sel & {NS{g_cyc}};
    assign s_stb_o    = s_cyc_o & {NS{g_stb & ~err_pend_q}};
    assign stb_active = |s_stb_o;
    assign ack        = stb_active & ack_sel;

    assign s_adr_o = g_adr;
    assign s_dat_o = g_dat;
    assign s_sel_o = g_sel;
    assign s_we_o  = g_we;
    assign m_dat_o = rdat;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_valid_q && gnt_q == GW'(i)) begin
                m_ack_o[i] = ack;
                m_err_o[i] = err_pend_q;
            end
        end
    end

    // Round robin: first requester above last, else first requester at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < NM; i++) begin
            if (m_cyc_i[i] && GW'(i) > last_q && !found_hi) begin
                found_hi = 1'b1;
                win_hi   = GW'(i);
            end
            if (m_cyc_i[i] && GW'(i) <= last_q && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = GW'(i);
            end
        end
        gnt_valid_d = gnt_valid_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        if (!gnt_valid_q || !g_cyc) begin
            gnt_valid_d = found_hi | found_lo;
            if (found_hi) begin
                gnt_d  = win_hi;
                last_d = win_hi;
            end else if (found_lo) begin
                gnt_d  = win_lo;
                last_d = win_lo;
            end
        end
    end

    // An ack in the final watchdog cycle takes precedence over the timeout.
    always_comb begin
        unmapped   = g_cyc & g_stb & ~sel_any & ~err_pend_q;
        wd_fire    = (TIMEOUT > 0) && stb_active && !ack && (wd_q == WD_LAST);
        err_pend_d = err_pend_q ? 1'b0 : (unmapped | wd_fire);
        if ((TIMEOUT == 0) || !stb_active || ack || wd_fire) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_valid_q <= 1'b0;
            gnt_q       <= '0;
            last_q      <= LAST_RST;
            wd_q        <= '0;
            err_pend_q  <= 1'b0;
        end else begin
            gnt_valid_q <= gnt_valid_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            err_pend_q  <= err_pend_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Bench for wb_rr_interconnect: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_wb_rr_interconnect;

    localparam int NM      = 2;
    localparam int NS      = 6;
    localparam int AW      = 3;
    localparam int TIMEOUT = 4;
    localparam logic [NS*AW-1:0] SA = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000};

    logic             clk;
    logic             rst;
    logic [NM*32-1:0] m_adr_i, m_dat_i;
    logic [NM*4-1:0]  m_sel_i;
    logic [NM-1:0]    m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;

    wb_rr_interconnect #(
        .NM(NM), .NS(NS), .AW(AW), .SLAVE_ADDRS(SA), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus state
    logic [31:0]   madr [NM];
    logic [31:0]   mdat [NM];
    logic [3:0]    msel [NM];
    logic [NM-1:0] mwe, mcyc, mstb;
    logic [31:0]   sdat [NS];
    logic [NS-1:0] ack_mask;

    always_comb begin
        m_adr_i = '0;
        m_dat_i = '0;
        m_sel_i = '0;
        for (int i = 0; i < NM; i++) begin
            m_adr_i[i*32 +: 32] = madr[i];
            m_dat_i[i*32 +: 32] = mdat[i];
            m_sel_i[i*4 +: 4]   = msel[i];
        end
        s_dat_i = '0;
        for (int i = 0; i < NS; i++) s_dat_i[i*32 +: 32] = sdat[i];
    end
    assign m_we_i  = mwe;
    assign m_cyc_i = mcyc;
    assign m_stb_i = mstb;
    // A slave acknowledges only while strobed and when its ack_mask bit allows.
    assign s_ack_i = s_stb_o & ack_mask;

    // Top three address bits each slave answers to.
    int slave_tag [NS] = '{0, 2, 3, 4, 5, 6};

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, want);
        end
    endtask

    // Reference model: who holds the bus, error pending, cycles the current strobe has stalled.
    logic mv, mep;
    int   mg, mlast, mstall;
    logic n_mv, n_mep;
    int   n_mg, n_mlast, n_mstall;

    logic [31:0]   e_adr, e_dat, e_mdat;
    logic [3:0]    e_sel;
    logic          e_we, e_hit, e_ack, stalled;
    logic [NS-1:0] e_scyc, e_sstb;
    logic [NM-1:0] e_mack, e_merr;
    int            e_sidx, cand;

    always_comb begin
        e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0;
        e_hit = 1'b0; e_sidx = 0;
        e_scyc = '0; e_sstb = '0; e_mack = '0; e_merr = '0; e_mdat = '0;
        if (mv) begin
            e_adr = madr[mg];
            e_dat = mdat[mg];
            e_sel = msel[mg];
            e_we  = mwe[mg];
            for (int i = NS - 1; i >= 0; i--) begin
                if (int'(madr[mg] >> 29) == slave_tag[i]) begin
                    e_hit  = 1'b1;
                    e_sidx = i;
                end
            end
        end
        if (e_hit) begin
            e_mdat = sdat[e_sidx];
            if (mcyc[mg]) begin
                e_scyc[e_sidx] = 1'b1;
                if (mstb[mg] && !mep) e_sstb[e_sidx] = 1'b1;
            end
        end
        e_ack = (e_sstb != '0) && ack_mask[e_sidx];
        if (e_ack) e_mack[mg] = 1'b1;
        if (mv && mep) e_merr[mg] = 1'b1;
    end

    always_comb begin
        n_mv = mv; n_mg = mg; n_mlast = mlast; n_mep = 1'b0; n_mstall = 0; cand = 0;
        stalled = (e_sstb != '0) && !e_ack;
        if (!mep) begin
            if (mv && mcyc[mg] && mstb[mg] && !e_hit) n_mep = 1'b1;
            else if (stalled && mstall == TIMEOUT - 1) n_mep = 1'b1;
            else if (stalled) n_mstall = mstall + 1;
        end
        if (!mv || !mcyc[mg]) begin
            n_mv = 1'b0;
            for (int k = NM; k >= 1; k--) begin
                cand = (mlast + k) % NM;
                if (mcyc[cand]) begin
                    n_mv = 1'b1; n_mg = cand; n_mlast = cand;
                end
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mv <= 1'b0; mg <= 0; mlast <= NM - 1; mep <= 1'b0; mstall <= 0;
        end else begin
            mv <= n_mv; mg <= n_mg; mlast <= n_mlast; mep <= n_mep; mstall <= n_mstall;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_adr_o", s_adr_o, e_adr);
            chk("s_dat_o", s_dat_o, e_dat);
            chk("s_sel_o", {28'd0, s_sel_o}, {28'd0, e_sel});
            chk("s_we_o", {31'd0, s_we_o}, {31'd0, e_we});
            chk("s_cyc_o", {26'd0, s_cyc_o}, {26'd0, e_scyc});
            chk("s_stb_o", {26'd0, s_stb_o}, {26'd0, e_sstb});
            chk("m_ack_o", {30'd0, m_ack_o}, {30'd0, e_mack});
            chk("m_err_o", {30'd0, m_err_o}, {30'd0, e_merr});
            chk("m_dat_o", m_dat_o, e_mdat);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mcyc = '0; mstb = '0; mwe = '0; ack_mask = '0;
        for (int i = 0; i < NM; i++) begin
            madr[i] = '0; mdat[i] = '0; msel[i] = '0;
        end
    endtask

    task automatic req(input int m, input logic [31:0] a);
        mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = 1'b0;
        madr[m] = a; mdat[m] = $urandom; msel[m] = 4'hf;
    endtask

    int            rec [4];
    int            rr_exp [4] = '{0, 1, 0, 1};
    int            nrec;
    logic [NM-1:0] got, done;
    logic          in_rst;

    initial begin
        idle();
        for (int i = 0; i < NS; i++) sdat[i] = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;

        // Reset values, then reset in the middle of a transfer to slave 2
        sdat[0] = 32'h1111_1111;
        @(negedge clk);
        chk("rst_scyc", {26'd0, s_cyc_o}, 32'd0);
        chk("rst_mdat", m_dat_o, 32'd0);
        chk("rst_sadr", s_adr_o, 32'd0);
        step();
        req(1, 32'h6000_0000);
        ack_mask = 6'b000100;
        @(negedge clk);
        chk("gnt_latency", {26'd0, s_cyc_o}, 32'd0);
        step();
        @(negedge clk);
        chk("pre_rst_scyc", {26'd0, s_cyc_o}, 32'h04);
        chk("pre_rst_ack", {30'd0, m_ack_o}, 32'h2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_scyc", {26'd0, s_cyc_o}, 32'd0);
        chk("async_rst_sstb", {26'd0, s_stb_o}, 32'd0);
        chk("async_rst_ack", {30'd0, m_ack_o}, 32'd0);
        chk("async_rst_err", {30'd0, m_err_o}, 32'd0);
        chk("async_rst_mdat", m_dat_o, 32'd0);
        idle();
        req(0, 32'h0000_0000);
        req(1, 32'h8000_0000);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {26'd0, s_cyc_o}, 32'd0);
        step();
        @(negedge clk);
        chk("post_rst_first_gnt", {26'd0, s_stb_o}, 32'h01);
        step(); idle(); step(); step();

        // Single read, two wait states
        req(1, 32'h6000_0004);
        sdat[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_t0_stb", {26'd0, s_stb_o}, 32'd0);
        for (int w = 0; w < 2; w++) begin
            step();
            @(negedge clk);
            chk("rd_wait_stb", {26'd0, s_stb_o}, 32'h04);
            chk("rd_wait_ack", {30'd0, m_ack_o}, 32'd0);
        end
        step();
        ack_mask[2] = 1'b1;
        @(negedge clk);
        chk("rd_stb", {26'd0, s_stb_o}, 32'h04);
        chk("rd_ack", {30'd0, m_ack_o}, 32'h2);
        chk("rd_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("rd_adr", s_adr_o, 32'h6000_0004);
        step(); idle(); step(); step();

        // Round robin: each master does one access per cycle, then drops cyc
        for (int k = 0; k < 4; k++) rec[k] = 99;
        nrec = 0;
        ack_mask = '1;
        req(0, 32'h0);
        req(1, 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            got = m_ack_o;
            if (nrec < 4 && got == 2'b01) begin rec[nrec] = 0; nrec++; end
            else if (nrec < 4 && got == 2'b10) begin rec[nrec] = 1; nrec++; end
            step();
            for (int m = 0; m < NM; m++) begin
                if (got[m]) begin
                    mcyc[m] = 1'b0; mstb[m] = 1'b0;
                end else if (!mcyc[m]) begin
                    req(m, 32'h0);
                end
            end
        end
        for (int k = 0; k < 4; k++) chk("rr_gnt_seq", rec[k], rr_exp[k]);
        idle(); step(); step();

        // Unmapped address (top bits 001)
        req(0, 32'h2000_0000);
        @(negedge clk);
        chk("um_t0_err", {30'd0, m_err_o}, 32'd0);
        step();
        @(negedge clk);
        chk("um_scyc", {26'd0, s_cyc_o}, 32'd0);
        chk("um_err_early", {30'd0, m_err_o}, 32'd0);
        step();
        @(negedge clk);
        chk("um_err", {30'd0, m_err_o}, 32'h1);
        chk("um_scyc_err", {26'd0, s_cyc_o}, 32'd0);
        step(); idle();
        @(negedge clk);
        chk("um_err_pulse", {30'd0, m_err_o}, 32'd0);
        step(); step();

        // Watchdog with a slave that never acks, then a retry
        req(0, 32'h0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                step();
                @(negedge clk);
                chk("wd_stb", {26'd0, s_stb_o}, 32'h01);
                chk("wd_no_err", {30'd0, m_err_o}, 32'd0);
            end
            step();
            @(negedge clk);
            chk("wd_stb_off", {26'd0, s_stb_o}, 32'd0);
            chk("wd_err", {30'd0, m_err_o}, 32'h1);
        end
        step(); idle(); step(); step();

        // Ack arrives in the last watchdog cycle
        req(0, 32'h0);
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            step();
            @(negedge clk);
            chk("race_wait_ack", {30'd0, m_ack_o}, 32'd0);
        end
        step();
        ack_mask[0] = 1'b1;
        @(negedge clk);
        chk("race_ack", {30'd0, m_ack_o}, 32'h1);
        chk("race_err", {30'd0, m_err_o}, 32'd0);
        step(); idle();
        @(negedge clk);
        chk("race_err_after", {30'd0, m_err_o}, 32'd0);
        step(); step();

        // Randomized traffic with occasional asynchronous resets
        in_rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            done = m_ack_o | m_err_o;
            step();
            for (int i = 0; i < NS; i++) begin
                ack_mask[i] = ($urandom_range(0, 2) == 0);
                sdat[i]     = $urandom;
            end
            for (int m = 0; m < NM; m++) begin
                if (!mcyc[m]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req(m, {3'($urandom_range(0, 7)), 29'($urandom)});
                        mwe[m]  = 1'($urandom);
                        msel[m] = 4'($urandom);
                    end
                end else if (done[m]) begin
                    case ($urandom_range(0, 3))
                        0, 1: begin mcyc[m] = 1'b0; mstb[m] = 1'b0; end
                        2: req(m, {3'($urandom_range(0, 7)), 29'($urandom)});
                        default: mstb[m] = 1'b0;
                    endcase
                end else if (!mstb[m]) begin
                    if ($urandom_range(0, 1) == 0)
                        req(m, {3'($urandom_range(0, 7)), 29'($urandom)});
                end else if ($urandom_range(0, 15) == 0) begin
                    mcyc[m] = 1'b0; mstb[m] = 1'b0;
                end
            end
            if (in_rst) begin
                #2 rst = 1'b1;
                in_rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                in_rst = 1'b1;
            end
        end
        step();
        rst = 1'b1;
        idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
